// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter
// Round-robin write arbiter in front of a shared WIDTH-bit register. One
// requester is granted per cycle; its data is captured into Q on the rising
// edge. A requester holding lock together with req keeps exclusive ownership
// until it drops lock.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   req      [N]        write request, bit i = requester i
//   lock     [N]        lock request, qualified by req[i] or lock ownership
//   wr_data  [N*WIDTH]  requester i data at [i*WIDTH +: WIDTH]
//   gnt      [N]        registered one-hot grant, one cycle per write
//   Q        [WIDTH]    shared register contents
//   owner    [IW]       index of the last requester written
//   valid               Q written at least once since reset
//   locked              arbiter currently in LOCKED
module shared_reg_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         lock,
    input  logic [N*WIDTH-1:0]   wr_data,
    output logic [N-1:0]         gnt,
    output logic [WIDTH-1:0]     Q,
    output logic [$clog2(N)-1:0] owner,
    output logic                 valid,
    output logic                 locked
);

    localparam int unsigned IW = $clog2(N);

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic              valid_q, valid_d;
    logic              locked_q, locked_d;

    logic              win_found;
    logic [IW-1:0]     win_idx;
    int unsigned       cand;
    logic [IW-1:0]     cand_idx;

    logic              wr_en;
    logic [IW-1:0]     sel_idx;
    logic [WIDTH-1:0]  sel_data;

    // Circular successor of a requester index; N-1 wraps to 0.
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] x);
        if (32'(x) == N - 1) begin
            return '0;
        end
        return x + IW'(1);
    endfunction

    // Round-robin search: first set req bit starting at ptr, wrapping at N-1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = 32'(ptr_q) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IW'(cand);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Next state, pointer and grant. In LOCKED only the owner's req/lock count.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = '0;
        owner_d  = owner_q;
        valid_d  = valid_q;
        wr_en    = 1'b0;
        sel_idx  = win_idx;

        case (state_q)
            ARB: begin
                if (win_found) begin
                    wr_en   = 1'b1;
                    sel_idx = win_idx;
                    if (lock[win_idx]) begin
                        state_d = LOCKED;
                    end else begin
                        ptr_d = next_idx(win_idx);
                    end
                end
            end
            LOCKED: begin
                sel_idx = owner_q;
                if (req[owner_q]) begin
                    wr_en = 1'b1;
                end
                if (!lock[owner_q]) begin
                    state_d = ARB;
                    ptr_d   = next_idx(owner_q);
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase

        if (wr_en) begin
            gnt_d[sel_idx] = 1'b1;
            owner_d        = sel_idx;
            valid_d        = 1'b1;
        end

        locked_d = (state_d == LOCKED);
    end

    // Data mux for the selected requester; Q only changes on a granting edge.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (sel_idx == IW'(i)) begin
                sel_data = wr_data[i*WIDTH +: WIDTH];
            end
        end
        q_d = wr_en ? sel_data : q_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB;
            ptr_q    <= '0;
            gnt_q    <= '0;
            q_q      <= '0;
            owner_q  <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            q_q      <= q_d;
            owner_q  <= owner_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
        end
    end

    assign gnt    = gnt_q;
    assign Q      = q_q;
    assign owner  = owner_q;
    assign valid  = valid_q;
    assign locked = locked_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench for shared_reg_arbiter (N=4, WIDTH=8). The stimulus
// process drives one vector per cycle and queues the hand-computed result;
// the monitor pops and compares after each rising edge.
module tb_shared_reg_arbiter;

    localparam int unsigned N     = 4;
    localparam int unsigned WIDTH = 8;

    typedef struct packed {
        logic [3:0] gnt;
        logic [7:0] q;
        logic [1:0] owner;
        logic       valid;
        logic       locked;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req;
    logic [N-1:0]     lock;
    logic [N*WIDTH-1:0] wr_data;
    logic [N-1:0]     gnt;
    logic [WIDTH-1:0] q;
    logic [1:0]       owner;
    logic             valid;
    logic             locked;

    logic [7:0] wd [4];

    exp_t sb[$];
    int   vectors;
    int   miscompares;
    int   vec_id;

    shared_reg_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .lock    (lock),
        .wr_data (wr_data),
        .gnt     (gnt),
        .Q       (q),
        .owner   (owner),
        .valid   (valid),
        .locked  (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        wr_data = '0;
        for (int i = 0; i < 4; i++) begin
            wr_data[i*8 +: 8] = wd[i];
        end
    end

    // Drive one vector at the falling edge and queue its expected result.
    task automatic step(input logic [3:0] r, input logic [3:0] l,
                        input logic [3:0] eg, input logic [7:0] eq,
                        input logic [1:0] eo, input logic ev, input logic el);
        exp_t e;
        @(negedge clk);
        rst  = 1'b0;
        req  = r;
        lock = l;
        e.gnt = eg; e.q = eq; e.owner = eo; e.valid = ev; e.locked = el;
        sb.push_back(e);
    endtask

    task automatic check_now(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: compare DUT outputs against the scoreboard after each edge.
    initial begin
        vec_id = 0;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                vec_id++;
                vectors++;
                if (gnt !== e.gnt || q !== e.q || owner !== e.owner ||
                    valid !== e.valid || locked !== e.locked) begin
                    miscompares++;
                    $display("FAIL vec%0d: got gnt=%b Q=%h owner=%0d valid=%b locked=%b expected gnt=%b Q=%h owner=%0d valid=%b locked=%b",
                             vec_id, gnt, q, owner, valid, locked,
                             e.gnt, e.q, e.owner, e.valid, e.locked);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst  = 1'b1;
        req  = '0;
        lock = '0;
        wd[0] = 8'h10; wd[1] = 8'h21; wd[2] = 8'h32; wd[3] = 8'h43;
        repeat (2) @(posedge clk);
        #3;
        check_now("reset_gnt", 32'(gnt), 32'h0);
        check_now("reset_q", 32'(q), 32'h0);
        check_now("reset_valid", 32'(valid), 32'h0);

        // Round robin with all requesting
        for (int c = 0; c < 8; c++) begin
            logic [3:0] eg;
            eg = 4'b0001 << (c % 4);
            step(4'hF, 4'h0, eg, wd[c % 4], 2'(c % 4), 1'b1, 1'b0);
        end

        // Pointer wrap and skip
        step(4'b1000, 4'h0, 4'b1000, 8'h43, 2'd3, 1'b1, 1'b0);
        step(4'b0101, 4'h0, 4'b0001, 8'h10, 2'd0, 1'b1, 1'b0);
        step(4'b0101, 4'h0, 4'b0100, 8'h32, 2'd2, 1'b1, 1'b0);
        step(4'b0001, 4'h0, 4'b0001, 8'h10, 2'd0, 1'b1, 1'b0);

        // Requester 1 locks while everyone requests
        for (int c = 0; c < 3; c++) begin
            step(4'hF, 4'b0010, 4'b0010, 8'h21, 2'd1, 1'b1, 1'b1);
        end
        step(4'hF, 4'h0, 4'b0010, 8'h21, 2'd1, 1'b1, 1'b0);
        step(4'hF, 4'h0, 4'b0100, 8'h32, 2'd2, 1'b1, 1'b0);

        // Lock owner 2 idles while holding lock
        step(4'b0100, 4'b0100, 4'b0100, 8'h32, 2'd2, 1'b1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step(4'b0001, 4'b0100, 4'b0000, 8'h32, 2'd2, 1'b1, 1'b1);
        end
        step(4'b0001, 4'h0, 4'b0000, 8'h32, 2'd2, 1'b1, 1'b0);
        step(4'b0001, 4'h0, 4'b0001, 8'h10, 2'd0, 1'b1, 1'b0);

        // Lock bit without its req in ARB has no effect
        step(4'b0010, 4'b0001, 4'b0010, 8'h21, 2'd1, 1'b1, 1'b0);

        // Idle after writing 0xA5
        wd[2] = 8'hA5;
        step(4'b0100, 4'h0, 4'b0100, 8'hA5, 2'd2, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            step(4'h0, 4'h0, 4'b0000, 8'hA5, 2'd2, 1'b1, 1'b0);
        end

        // Reset mid-lock with all requesting
        step(4'b1000, 4'b1000, 4'b1000, 8'h43, 2'd3, 1'b1, 1'b1);
        @(posedge clk);
        #3;
        req = 4'hF;
        rst = 1'b1;
        #1;
        check_now("midrst_gnt", 32'(gnt), 32'h0);
        check_now("midrst_q", 32'(q), 32'h0);
        check_now("midrst_owner", 32'(owner), 32'h0);
        check_now("midrst_valid", 32'(valid), 32'h0);
        check_now("midrst_locked", 32'(locked), 32'h0);
        step(4'hF, 4'h0, 4'b0001, 8'h10, 2'd0, 1'b1, 1'b0);
        step(4'hF, 4'h0, 4'b0010, 8'h21, 2'd1, 1'b1, 1'b0);

        @(negedge clk);
        req = '0;
        repeat (3) @(posedge clk);
        #3;
        check_now("sb_drained", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Round-robin write arbiter for a shared WIDTH-bit D-flip-flop register. N requesters compete to load the register. The block selects one requester per cycle, captures that requester's data on the rising clock edge, and reports the grant, the owner index and a valid flag. An optional per-requester lock gives one requester exclusive ownership across several writes. It sits between requester logic and any consumer of the shared register value Q.

## Interface
- N, default 4: number of requesters, N >= 2.
- WIDTH, default 8: width of the shared register.
- IW, derived as $clog2(N) (not overridable): width of the owner index.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  write request; bit i belongs to requester i.
- lock  input  N  lock request; bit i is meaningful only together with req[i], or while requester i is the lock owner.
- wr_data  input  N*WIDTH  requester i data on bits [i*WIDTH +: WIDTH].
- gnt  output  N  registered, one-hot or zero; high for one cycle per write performed.
- Q  output  WIDTH  shared register contents.
- owner  output  IW  index of the last requester written; holds its value between grants.
- valid  output  1  Q has been written at least once since reset.
- locked  output  1  the arbiter is in state LOCKED.

## Operation
- Reset (asynchronous, applies immediately): gnt=0, Q=0, owner=0, valid=0, locked=0, state=ARB, round-robin pointer ptr=0.
- State ARB:
  - Winner is the first set bit of req, searching circularly from ptr upward (ptr, ptr+1, ..., wrapping at N-1 to 0).
  - If any req bit is set, at the edge: Q<=wr_data[winner], gnt<=onehot(winner), owner<=winner, valid<=1.
  - If req[winner] && lock[winner]: go to LOCKED, ptr unchanged. Otherwise stay in ARB with ptr<=(winner+1) mod N.
  - If req==0: gnt<=0; Q, owner, valid and ptr hold.
- State LOCKED (lock owner k = owner):
  - Only req[k] is considered; all other req bits are ignored, so no grants go to other requesters.
  - req[k]&&lock[k]: write as above, stay LOCKED.
  - req[k]&&!lock[k]: write (the final write), go to ARB, ptr<=(k+1) mod N.
  - !req[k]&&lock[k]: no write, gnt=0, stay LOCKED.
  - !req[k]&&!lock[k]: no write, go to ARB, ptr<=(k+1) mod N.
- locked equals (state==LOCKED), registered.
- No write ever occurs without a matching gnt bit in the following cycle. Q changes only on a granting edge.
- Requesters may hold req across cycles. A continuously requesting requester competes again every cycle.

## Timing
- Arbitration and selection of wr_data are combinational from req, lock, wr_data, ptr and state, all sampled at the rising edge.
- Latency is 1 cycle. Request sampled at edge t gives gnt, Q, owner and valid updated after edge t, visible during cycle t+1.
- Back-to-back grants are allowed: one write per cycle maximum, with no idle cycle between grants.
- Fairness: in ARB with all N requesting continuously, grants rotate 0,1,...,N-1,0. No requester waits more than N-1 grants.
- Pointer wrap: winner N-1 sets ptr to 0.
- Reset asserted mid-lock or mid-burst: all state clears at once. After deassertion the first arbitration starts from ptr=0 in ARB.
- A lock bit without its req bit in ARB has no effect.

## Test plan
- Reset: assert rst mid-cycle with req=4'b1111 -> all outputs 0 immediately. After release, first gnt=4'b0001 with Q=wr_data[0].
- Round-robin: N=4, req=4'b1111 held for 8 cycles, wr_data words 0x10,0x21,0x32,0x43 -> gnt sequence 0001,0010,0100,1000,0001,... Q follows 0x10,0x21,0x32,0x43,... and owner cycles 0..3.
- Pointer skip/wrap: grant to requester 3, then req=4'b0101 -> next gnt=0001, then 0100.
- Lock: requester 1 asserts req+lock while req=4'b1111 -> gnt=0010 for every cycle while lock[1] is held and locked=1. Requester 1 then drops lock with req[1]=1 -> one final gnt=0010, locked=0, next gnt=0100.
- Lock hold idle: lock owner 2 drops req with lock[2]=1 for 3 cycles while req[0]=1 -> gnt=0 and Q holds. Lock[2] then drops -> ARB, and the next gnt goes to 0001 (search from ptr=3 wraps to 0).
- Idle: req=0 after a write of 0xA5 -> gnt=0, while Q=0xA5, owner and valid=1 persist indefinitely.
